// File: rtl/svc_soc_io_pkg.sv
// svc_soc_io_pkg: register offsets, STATUS/CTRL bit positions and TX FSM states for the SoC I/O UART scheduler
package svc_soc_io_pkg;
  localparam logic [3:0] OFF_DATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;
  localparam int ST_FULL = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_COUNT = 8;
  localparam int CTRL_EN = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_IRQ_EN = 2;
  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} tx_state_e;
endpackage

// File: rtl/svc_sync_fifo.sv
// svc_sync_fifo: sync FIFO (clk, rst, push/wdata in, pop/rdata head out, flush, count/full/empty); push while full only lands with a pop, flush wins
module svc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  assign pop_ok = pop && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push_ok ? wp + 1'b1 : wp;
      rp <= pop_ok ? rp + 1'b1 : rp;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= wdata;
  end
endmodule

// File: rtl/svc_soc_uart_tx_sched.sv
// svc_soc_uart_tx_sched: bus-mapped UART TX scheduler (io_w*/io_r* register bus, utx_* valid/ready byte stream, irq low-water level)
module svc_soc_uart_tx_sched
  import svc_soc_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0100,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  output logic        utx_valid,
  output logic [7:0]  utx_data,
  input  logic        utx_ready,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || LOW_WATER < 0 ||
      LOW_WATER >= FIFO_DEPTH || BASE_ADDR[3:0] != 4'h0) begin : g_param_check
    $error("svc_soc_uart_tx_sched: FIFO_DEPTH must be a power of 2 >= 2, LOW_WATER < FIFO_DEPTH, BASE_ADDR 16-byte aligned");
  end
  tx_state_e state;
  logic enable, irq_en, ovf;
  logic [CW-1:0] count;
  logic full, empty, busy;
  logic [7:0] head;
  logic w_hit, r_hit, push, pop, ctrl_wr, flush, ovf_set, ovf_clr;
  logic [31:0] status, ctrl, rdata_nx;
  logic unused;
  assign unused = ^{io_wdata[31:8], io_wstrb[3:1]};
  always_comb begin
    w_hit = io_wen && io_waddr[31:4] == BASE_ADDR[31:4];
    r_hit = io_raddr[31:4] == BASE_ADDR[31:4];
    push = w_hit && io_waddr[3:0] == OFF_DATA && io_wstrb[0];
    ctrl_wr = w_hit && io_waddr[3:0] == OFF_CTRL && io_wstrb[0];
    flush = ctrl_wr && io_wdata[CTRL_FLUSH];
    ovf_clr = w_hit && io_waddr[3:0] == OFF_STATUS && io_wstrb[0] && io_wdata[ST_OVF];
    pop = state == S_IDLE && enable && !empty;
    ovf_set = push && full && !pop && !flush;
    busy = state == S_SEND || !empty;
    status = '0;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY] = busy;
    status[ST_OVF] = ovf;
    status[ST_COUNT +: 8] = 8'(count);
    ctrl = '0;
    ctrl[CTRL_EN] = enable;
    ctrl[CTRL_IRQ_EN] = irq_en;
    rdata_nx = !r_hit ? '0 : io_raddr[3:0] == OFF_STATUS ? status : io_raddr[3:0] == OFF_CTRL ? ctrl : '0;
  end
  assign irq = irq_en && count <= CW'(LOW_WATER);
  svc_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata(io_wdata[7:0]),
    .pop(pop),
    .flush(flush),
    .rdata(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b1;
      irq_en <= 1'b0;
      ovf <= 1'b0;
      io_rdata <= '0;
    end else begin
      enable <= ctrl_wr ? io_wdata[CTRL_EN] : enable;
      irq_en <= ctrl_wr ? io_wdata[CTRL_IRQ_EN] : irq_en;
      ovf <= ovf_set || (ovf && !ovf_clr);
      io_rdata <= io_ren ? rdata_nx : io_rdata;
    end
  end
  // The popped head is held in utx_data for the whole SEND; only the handshake ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      utx_valid <= 1'b0;
      utx_data <= '0;
    end else if (state == S_IDLE) begin
      state <= pop ? S_SEND : S_IDLE;
      utx_valid <= pop;
      utx_data <= pop ? head : utx_data;
    end else if (utx_ready) begin
      state <= S_IDLE;
      utx_valid <= 1'b0;
    end
  end
endmodule
